// File: rtl/ddr2_wr_arbiter.sv
// ddr2_wr_arbiter: two-requester arbiter sharing DDR2 address/write-data FIFOs, per-transaction grant.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break in IDLE; otherwise r0 always wins ties.
module ddr2_wr_arbiter #(
    parameter int BEATS_PER_CMD = 2,
    parameter int MAX_BURSTS    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         r0_req,
    input  logic [30:0]  r0_af_addr_din,
    input  logic         r0_af_wr_en,
    input  logic [127:0] r0_wdf_din,
    input  logic [15:0]  r0_wdf_mask_din,
    input  logic         r0_wdf_wr_en,
    output logic         r0_af_full,
    output logic         r0_wdf_full,
    input  logic         r1_req,
    input  logic [30:0]  r1_af_addr_din,
    input  logic         r1_af_wr_en,
    input  logic [127:0] r1_wdf_din,
    input  logic [15:0]  r1_wdf_mask_din,
    input  logic         r1_wdf_wr_en,
    output logic         r1_af_full,
    output logic         r1_wdf_full,
    input  logic         af_full,
    input  logic         wdf_full,
    output logic [30:0]  af_addr_din,
    output logic         af_wr_en,
    output logic [127:0] wdf_din,
    output logic [15:0]  wdf_mask_din,
    output logic         wdf_wr_en,
    output logic [1:0]   grant
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state;
    logic af_done;
    logic [2:0] beat_cnt;
    logic [7:0] burst_cnt;
    logic g0, g1, busy, cur_af_full, cur_wdf_full, done_now, own_req, oth_req, stay, pick1;
    logic [2:0] beats_next;
    assign g0 = state == GNT0;
    assign g1 = state == GNT1;
    assign busy = g0 | g1;
    assign grant = {g1, g0};
    assign cur_af_full = af_full | af_done;
    assign cur_wdf_full = wdf_full | (beat_cnt == 3'(BEATS_PER_CMD));
    assign r0_af_full = g0 ? cur_af_full : 1'b1;
    assign r0_wdf_full = g0 ? cur_wdf_full : 1'b1;
    assign r1_af_full = g1 ? cur_af_full : 1'b1;
    assign r1_wdf_full = g1 ? cur_wdf_full : 1'b1;
    assign af_wr_en = busy & (g1 ? r1_af_wr_en : r0_af_wr_en) & ~cur_af_full;
    assign wdf_wr_en = busy & (g1 ? r1_wdf_wr_en : r0_wdf_wr_en) & ~cur_wdf_full;
    assign af_addr_din = g1 ? r1_af_addr_din : g0 ? r0_af_addr_din : '0;
    assign wdf_din = g1 ? r1_wdf_din : g0 ? r0_wdf_din : '0;
    assign wdf_mask_din = g1 ? r1_wdf_mask_din : g0 ? r0_wdf_mask_din : '0;
    assign beats_next = beat_cnt + 3'(wdf_wr_en);
    // af and the last beat may land together; either order completes the transaction
    assign done_now = (af_done | af_wr_en) & (beats_next == 3'(BEATS_PER_CMD));
    assign own_req = g1 ? r1_req : r0_req;
    assign oth_req = g1 ? r0_req : r1_req;
    assign stay = own_req & (~oth_req | (burst_cnt < 8'(MAX_BURSTS - 1)));
`ifdef ARB_ROUND_ROBIN_EN
    logic last_gnt;
    always_ff @(posedge clk or posedge rst)
        if (rst) last_gnt <= 1'b1;
        else if (busy) last_gnt <= g1;
    assign pick1 = r1_req & (~r0_req | ~last_gnt);
`else
    assign pick1 = r1_req & ~r0_req;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            af_done <= 1'b0;
            beat_cnt <= '0;
            burst_cnt <= '0;
        end else if (state == IDLE) begin
            if (r0_req | r1_req) state <= pick1 ? GNT1 : GNT0;
            af_done <= 1'b0;
            beat_cnt <= '0;
            burst_cnt <= '0;
        end else if (done_now) begin
            af_done <= 1'b0;
            beat_cnt <= '0;
            if (stay) burst_cnt <= burst_cnt + 8'd1;
            else begin
                burst_cnt <= '0;
                state <= oth_req ? (g0 ? GNT1 : GNT0) : IDLE;
            end
        end else begin
            af_done <= af_done | af_wr_en;
            beat_cnt <= beats_next;
        end
    end
endmodule

// File: tb/tb_ddr2_wr_arbiter.sv
// tb_ddr2_wr_arbiter: randomized and directed stimulus against a transaction-level reference model.
module tb_ddr2_wr_arbiter;
    localparam int B = 2, M = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [1:0] req = '0, af_we = '0, wdf_we = '0;
    logic [30:0] addr [2];
    logic [127:0] din [2];
    logic [15:0] mask [2];
    logic af_full = 1'b0, wdf_full = 1'b0;
    logic r0_af_full, r0_wdf_full, r1_af_full, r1_wdf_full, af_wr_en, wdf_wr_en;
    logic [30:0] af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0] wdf_mask_din;
    logic [1:0] grant;
    int vectors = 0, miscompares = 0;
    int own, m_beats, m_bursts, last;
    bit m_af;

    always #5 clk = ~clk;

    ddr2_wr_arbiter #(.BEATS_PER_CMD(B), .MAX_BURSTS(M)) dut (
        .clk(clk), .rst(rst),
        .r0_req(req[0]), .r0_af_addr_din(addr[0]), .r0_af_wr_en(af_we[0]),
        .r0_wdf_din(din[0]), .r0_wdf_mask_din(mask[0]), .r0_wdf_wr_en(wdf_we[0]),
        .r0_af_full(r0_af_full), .r0_wdf_full(r0_wdf_full),
        .r1_req(req[1]), .r1_af_addr_din(addr[1]), .r1_af_wr_en(af_we[1]),
        .r1_wdf_din(din[1]), .r1_wdf_mask_din(mask[1]), .r1_wdf_wr_en(wdf_we[1]),
        .r1_af_full(r1_af_full), .r1_wdf_full(r1_wdf_full),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .grant(grant)
    );

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        own = -1; m_af = 0; m_beats = 0; m_bursts = 0; last = 1;
    endtask

    task automatic new_data();
        for (int i = 0; i < 2; i++) begin
            addr[i] = 31'($urandom);
            din[i] = {$urandom, $urandom, $urandom, $urandom};
            mask[i] = 16'($urandom);
        end
    endtask

    // compare outputs mid-cycle, then advance the model as the clock edge would
    task automatic tick(input string tag);
        logic [1:0] ef_af, ef_wdf, eg;
        bit eaf, ewdf, a;
        int bt, o, w;
        #2;
        ef_af = 2'b11; ef_wdf = 2'b11; eaf = 0; ewdf = 0; eg = 2'b00;
        if (own >= 0) begin
            ef_af[own] = af_full | m_af;
            ef_wdf[own] = wdf_full | (m_beats == B);
            eaf = af_we[own] & ~ef_af[own];
            ewdf = wdf_we[own] & ~ef_wdf[own];
            eg[own] = 1'b1;
        end
        check({tag, ".ctl"}, 192'({grant, af_wr_en, wdf_wr_en, r1_af_full, r0_af_full, r1_wdf_full, r0_wdf_full}),
              192'({eg, eaf, ewdf, ef_af, ef_wdf}));
        check({tag, ".data"}, 192'({af_addr_din, wdf_mask_din, wdf_din}),
              own >= 0 ? 192'({addr[own], mask[own], din[own]}) : 192'(0));
        if (own >= 0) last = own;
        if (own < 0) begin
            if (req != 2'b00) begin
`ifdef ARB_ROUND_ROBIN_EN
                w = (req == 2'b11) ? 1 - last : (req[0] ? 0 : 1);
`else
                w = req[0] ? 0 : 1;
`endif
                own = w;
            end
            m_bursts = 0;
        end else begin
            a = m_af | eaf;
            bt = m_beats + int'(ewdf);
            if (a && bt == B) begin
                o = 1 - own;
                if (req[own] && (!req[o] || m_bursts < M - 1)) m_bursts++;
                else begin
                    m_bursts = 0;
                    own = req[o] ? o : -1;
                end
                m_af = 0; m_beats = 0;
            end else begin
                m_af = a; m_beats = bt;
            end
        end
        @(posedge clk);
        #1;
        new_data();
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #2;
        check({tag, ".rst"}, 192'({grant, af_wr_en, wdf_wr_en, r1_af_full, r0_af_full, r1_wdf_full, r0_wdf_full}),
              192'(8'b00_00_1111));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        new_data();
        model_reset();
        @(posedge clk);
        #1;
        pulse_reset("init");
        // single requester: one af and two beats, excess beat blocked, then idle
        req = 2'b01; af_we = 2'b01; wdf_we = 2'b01;
        for (int i = 0; i < 4; i++) tick("solo");
        req = 2'b00; af_we = 0; wdf_we = 0;
        for (int i = 0; i < 3; i++) tick("solo_idle");
        // simultaneous requests, then both drop and re-request together
        req = 2'b11; af_we = 2'b11; wdf_we = 2'b11;
        tick("tie");
        tick("tie");
        req = 2'b00;
        for (int i = 0; i < 3; i++) tick("tie_drop");
        req = 2'b11;
        for (int i = 0; i < 4; i++) tick("tie2");
        // continuous streaming exercises burst fairness
        for (int i = 0; i < 30; i++) tick("stream");
        // DDR2 data FIFO stalled mid-transaction
        pulse_reset("pre_stall");
        req = 2'b11; af_we = 2'b11; wdf_we = 2'b11;
        tick("stall_start");
        tick("stall_start");
        wdf_full = 1'b1;
        for (int i = 0; i < 10; i++) tick("stall");
        wdf_full = 1'b0;
        for (int i = 0; i < 4; i++) tick("stall_rel");
        // reset after af plus one beat, then a fresh r1 transaction
        pulse_reset("pre_abort");
        req = 2'b01; af_we = 2'b01; wdf_we = 2'b01;
        tick("abort");
        tick("abort");
        pulse_reset("abort");
        req = 2'b10; af_we = 2'b10; wdf_we = 2'b10;
        for (int i = 0; i < 4; i++) tick("fresh_r1");
        // r0 drops req after its af write; grant held until its beats finish
        pulse_reset("pre_drop");
        req = 2'b01; af_we = 2'b01; wdf_we = 2'b00;
        tick("drop");
        tick("drop");
        req = 2'b00; af_we = 0;
        tick("drop");
        wdf_we = 2'b01;
        for (int i = 0; i < 4; i++) tick("drop");
        // randomized traffic with occasional async resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) pulse_reset("rnd");
            req = {2{$urandom_range(0, 99) < 75}} & 2'($urandom | {$urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0});
            af_we = 2'($urandom);
            wdf_we = 2'($urandom);
            af_full = $urandom_range(0, 99) < 15;
            wdf_full = $urandom_range(0, 99) < 15;
            tick("rnd");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
